mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter_if.sv | 53 +++++
 rtl/mem_arbiter_sat_counter.sv | 48 ++++
 rtl/mem_arbiter.sv | 112 +++++++++++
 tb/tb_mem_arbiter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the CPU/display memory arbiter: owner encodings that
// record which requester's read is returning data, and the default address
// width and screen window base used by the arbiter and its bus interface.
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam int                DEFAULT_ADDR_W      = 12;
    localparam logic [11:0]       DEFAULT_SCREEN_BASE = 12'h100;

    // Who owns the read data arriving from memory this cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DISP = 2'd2
    } owner_e;

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the CPU port, display port and memory port of the arbiter.
//   slave  : arbiter side (consumes requests and mem_rdata, drives grants,
//            read-data returns and the memory command).
//   master : environment side (CPU, display and memory model).
//
// Handshake: a requester raises *_req with a stable address (and write data)
// and holds them until it sees *_gnt high in the same cycle; that cycle is the
// access. For reads, *_rvalid is high exactly one cycle later together with
// *_rdata; *_rdata reads 0 whenever *_rvalid is low. Writes return nothing.
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int ADDR_W = 12
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [7:0]        cpu_rdata;

    logic              disp_req;
    logic [7:0]        disp_addr;
    logic              disp_gnt;
    logic              disp_rvalid;
    logic [7:0]        disp_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  disp_req, disp_addr,
        input  mem_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output disp_gnt, disp_rvalid, disp_rdata,
        output mem_addr, mem_we, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output disp_req, disp_addr,
        output mem_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  disp_gnt, disp_rvalid, disp_rdata,
        input  mem_addr, mem_we, mem_wdata
    );

endinterface : mem_arbiter_if

// File: rtl/mem_arbiter_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used to measure how long the display has waited.
// Ports:
//   clk, reset : clock, synchronous active-high reset (clears count)
//   inc        : count up by one unless already at LIMIT
//   clr        : return to zero (wins over inc)
//   cnt        : current count
//   at_limit   : count equals LIMIT
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int LIMIT = 8,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         at_limit
);

    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LIM)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt      = cnt_q;
    assign at_limit = (cnt_q == LIM);

endmodule : sat_counter

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one synchronous-read byte memory between a CPU and a display fetcher.
// The CPU normally wins; once the display has waited MAX_WAIT cycles it takes
// the next slot. Grants are combinational so an access can issue every cycle.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   bus (slave)   : CPU port, display port, memory port (see mem_arbiter_if)
//   dbg_owner     : registered owner of the read data returning this cycle
//   dbg_wait_cnt  : display starvation counter
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int                ADDR_W      = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] SCREEN_BASE = ADDR_W'(DEFAULT_SCREEN_BASE),
    parameter int                MAX_WAIT    = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    mem_arbiter_if.slave                  bus,
    output owner_e                        dbg_owner,
    output logic [$clog2(MAX_WAIT+1)-1:0] dbg_wait_cnt
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic              cpu_gnt;
    logic              disp_gnt;
    logic              starved;
    logic              wait_inc;
    logic              wait_clr;
    logic [CW-1:0]     wait_cnt;
    logic [ADDR_W-1:0] disp_full_addr;

    logic [ADDR_W-1:0] mem_addr_q;
    logic [ADDR_W-1:0] mem_addr_d;
    owner_e            owner_q;
    owner_e            owner_d;

    // Offset is zero-extended; the sum wraps within ADDR_W bits.
    assign disp_full_addr = SCREEN_BASE + {{(ADDR_W-8){1'b0}}, bus.disp_addr};

    // The CPU keeps the slot unless the display is also asking and starved.
    always_comb begin
        cpu_gnt  = 1'b0;
        disp_gnt = 1'b0;
        if (!reset) begin
            if (bus.cpu_req && !(bus.disp_req && starved)) begin
                cpu_gnt = 1'b1;
            end else if (bus.disp_req) begin
                disp_gnt = 1'b1;
            end
        end
    end

    assign wait_inc = bus.disp_req && !disp_gnt;
    assign wait_clr = disp_gnt || !bus.disp_req;

    sat_counter #(
        .LIMIT (MAX_WAIT),
        .W     (CW)
    ) u_wait_cnt (
        .clk      (clk),
        .reset    (reset),
        .inc      (wait_inc),
        .clr      (wait_clr),
        .cnt      (wait_cnt),
        .at_limit (starved)
    );

    // Address follows the granted requester, otherwise holds the last value.
    // Owner tracks reads only, so a CPU write returns no rvalid.
    always_comb begin
        mem_addr_d = mem_addr_q;
        owner_d    = OWN_NONE;
        if (cpu_gnt) begin
            mem_addr_d = bus.cpu_addr;
            owner_d    = bus.cpu_we ? OWN_NONE : OWN_CPU;
        end else if (disp_gnt) begin
            mem_addr_d = disp_full_addr;
            owner_d    = OWN_DISP;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr_q <= '0;
            owner_q    <= OWN_NONE;
        end else begin
            mem_addr_q <= mem_addr_d;
            owner_q    <= owner_d;
        end
    end

    assign bus.cpu_gnt   = cpu_gnt;
    assign bus.disp_gnt  = disp_gnt;
    assign bus.mem_addr  = mem_addr_d;
    assign bus.mem_we    = cpu_gnt && bus.cpu_we;
    assign bus.mem_wdata = bus.cpu_wdata;

    // Gating by reset keeps a grant from just before reset from returning
    // data while reset is asserted.
    assign bus.cpu_rvalid  = !reset && (owner_q == OWN_CPU);
    assign bus.disp_rvalid = !reset && (owner_q == OWN_DISP);
    assign bus.cpu_rdata   = bus.cpu_rvalid  ? bus.mem_rdata : 8'h00;
    assign bus.disp_rdata  = bus.disp_rvalid ? bus.mem_rdata : 8'h00;

    assign dbg_owner    = owner_q;
    assign dbg_wait_cnt = wait_cnt;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: directed table of single-cycle vectors,
// hand-written multi-cycle sequences (starvation rotation, reset after a
// display grant) and a randomized phase checked against a cycle-level model.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int MAX_WAIT    = 8;
    localparam int SCREEN_BASE = 'h100;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(12)) bus ();
    owner_e     dbg_owner;
    logic [3:0] dbg_wait;

    mem_arbiter #(
        .ADDR_W      (12),
        .SCREEN_BASE (12'h100),
        .MAX_WAIT    (MAX_WAIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.slave),
        .dbg_owner    (dbg_owner),
        .dbg_wait_cnt (dbg_wait)
    );

    // ---------------- memory environment (1-cycle synchronous read) ----------------
    logic [7:0]  env_mem [4096];
    logic        init_en = 1'b1;
    logic        poke_en = 1'b0;
    logic [11:0] poke_addr = '0;
    logic [7:0]  poke_data = '0;

    always @(posedge clk) begin
        if (init_en) begin
            for (int i = 0; i < 4096; i++) env_mem[i] <= 8'((i * 7 + 3) & 255);
        end else if (poke_en) begin
            env_mem[poke_addr] <= poke_data;
        end else if (bus.mem_we) begin
            env_mem[bus.mem_addr] <= bus.mem_wdata;
        end
        bus.mem_rdata <= env_mem[bus.mem_addr];
    end

    // ---------------- scoreboard counters ----------------
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Display is served when alone or after waiting MAX_WAIT cycles; the CPU
    // is served otherwise. Read data is predicted from a shadow memory.
    logic [7:0]  ref_mem [4096];
    int          m_wait = 0;
    logic [11:0] m_addr = '0;
    bit          m_addr_known = 1'b0;
    int          m_pend = 0;          // 0 none, 1 cpu read, 2 display read
    logic [7:0]  m_pend_data = '0;

    // One clock cycle: drive at negedge, check outputs 1 time unit later.
    task automatic step(input logic rst, input logic creq, input logic cwe,
                        input logic [11:0] caddr, input logic [7:0] cwd,
                        input logic dreq, input logic [7:0] daddr);
        bit          dt, ct;
        logic [11:0] ea;
        @(negedge clk);
        reset         = rst;
        bus.cpu_req   = creq;
        bus.cpu_we    = cwe;
        bus.cpu_addr  = caddr;
        bus.cpu_wdata = cwd;
        bus.disp_req  = dreq;
        bus.disp_addr = daddr;
        #1;
        if (rst) begin
            chk("rst_cpu_gnt",     32'(bus.cpu_gnt),     32'd0);
            chk("rst_disp_gnt",    32'(bus.disp_gnt),    32'd0);
            chk("rst_mem_we",      32'(bus.mem_we),      32'd0);
            chk("rst_cpu_rvalid",  32'(bus.cpu_rvalid),  32'd0);
            chk("rst_disp_rvalid", 32'(bus.disp_rvalid), 32'd0);
            if (m_addr_known) chk("rst_mem_addr", 32'(bus.mem_addr), 32'(m_addr));
            m_wait = 0;
            m_pend = 0;
            m_addr = '0;
            m_addr_known = 1'b1;
        end else begin
            dt = dreq && (!creq || m_wait >= MAX_WAIT);
            ct = creq && !dt;
            ea = ct ? caddr : (dt ? 12'((SCREEN_BASE + int'(daddr)) % 4096) : m_addr);
            chk("m_cpu_gnt",     32'(bus.cpu_gnt),     32'(ct));
            chk("m_disp_gnt",    32'(bus.disp_gnt),    32'(dt));
            chk("m_mem_we",      32'(bus.mem_we),      32'(ct && cwe));
            chk("m_mem_addr",    32'(bus.mem_addr),    32'(ea));
            chk("m_wait_cnt",    32'(dbg_wait),        32'(m_wait));
            chk("m_cpu_rvalid",  32'(bus.cpu_rvalid),  32'(m_pend == 1));
            chk("m_disp_rvalid", 32'(bus.disp_rvalid), 32'(m_pend == 2));
            chk("m_cpu_rdata",   32'(bus.cpu_rdata),   (m_pend == 1) ? 32'(m_pend_data) : 32'd0);
            chk("m_disp_rdata",  32'(bus.disp_rdata),  (m_pend == 2) ? 32'(m_pend_data) : 32'd0);
            if (ct && cwe) begin
                bus.cpu_wdata = cwd;
                if (bus.mem_wdata !== cwd) chk("m_mem_wdata", 32'(bus.mem_wdata), 32'(cwd));
                ref_mem[ea] = cwd;
                m_pend = 0;
            end else if (ct || dt) begin
                m_pend      = ct ? 1 : 2;
                m_pend_data = ref_mem[ea];
            end else begin
                m_pend = 0;
            end
            m_addr = ea;
            m_wait = (dreq && !dt) ? ((m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1) : 0;
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        creq;  logic cwe; logic [11:0] caddr; logic [7:0] cwd;
        logic        dreq;  logic [7:0] daddr;
        logic        ecg;   logic edg; logic [11:0] eaddr; logic ewe;
        logic        ecrv;  logic [7:0] ecrd;
        logic        edrv;  logic [7:0] edrd;
    } vec_t;

    vec_t tbl [11];

    logic        r_creq, r_cwe, r_dreq, r_rst, prev_cg, prev_dg, prev_rst;
    logic [11:0] r_caddr;
    logic [7:0]  r_cwd, r_daddr;

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'((i * 7 + 3) & 255);

        //          creq we  caddr   wd     dreq daddr  | cg dg addr    we crv crd    drv drd
        tbl[0]  = '{1, 0, 12'h020, 8'h00, 0, 8'h00,   1, 0, 12'h020, 0, 0, 8'h00, 0, 8'h00};
        tbl[1]  = '{0, 0, 12'h000, 8'h00, 0, 8'h00,   0, 0, 12'h020, 0, 1, 8'h42, 0, 8'h00};
        tbl[2]  = '{0, 0, 12'h000, 8'h00, 1, 8'h38,   0, 1, 12'h138, 0, 0, 8'h00, 0, 8'h00};
        tbl[3]  = '{0, 0, 12'h000, 8'h00, 0, 8'h00,   0, 0, 12'h138, 0, 0, 8'h00, 1, 8'hA7};
        tbl[4]  = '{1, 1, 12'h02F, 8'h55, 1, 8'h00,   1, 0, 12'h02F, 1, 0, 8'h00, 0, 8'h00};
        tbl[5]  = '{1, 0, 12'h02F, 8'h00, 1, 8'h00,   1, 0, 12'h02F, 0, 0, 8'h00, 0, 8'h00};
        tbl[6]  = '{0, 0, 12'h000, 8'h00, 1, 8'h00,   0, 1, 12'h100, 0, 1, 8'h55, 0, 8'h00};
        tbl[7]  = '{0, 0, 12'h000, 8'h00, 1, 8'hFF,   0, 1, 12'h1FF, 0, 0, 8'h00, 1, 8'h22};
        tbl[8]  = '{0, 0, 12'h000, 8'h00, 1, 8'h00,   0, 1, 12'h100, 0, 0, 8'h00, 1, 8'h11};
        tbl[9]  = '{0, 0, 12'h000, 8'h00, 0, 8'h00,   0, 0, 12'h100, 0, 0, 8'h00, 1, 8'h22};
        tbl[10] = '{0, 0, 12'h000, 8'h00, 0, 8'h00,   0, 0, 12'h100, 0, 0, 8'h00, 0, 8'h00};

        // Reset with both requests high; preload memory while in reset.
        step(1, 1, 0, 12'h020, 8'h00, 1, 8'h38);
        init_en = 1'b0;
        poke_en = 1'b1; poke_addr = 12'h020; poke_data = 8'h42; ref_mem[12'h020] = 8'h42;
        step(1, 1, 0, 12'h020, 8'h00, 1, 8'h38);
        poke_addr = 12'h138; poke_data = 8'hA7; ref_mem[12'h138] = 8'hA7;
        step(1, 1, 0, 12'h020, 8'h00, 1, 8'h38);
        poke_addr = 12'h1FF; poke_data = 8'h11; ref_mem[12'h1FF] = 8'h11;
        step(1, 0, 0, 12'h000, 8'h00, 0, 8'h00);
        poke_addr = 12'h100; poke_data = 8'h22; ref_mem[12'h100] = 8'h22;
        step(1, 0, 0, 12'h000, 8'h00, 0, 8'h00);
        poke_en = 1'b0;

        // First cycle out of reset: cleared state.
        step(0, 0, 0, 12'h000, 8'h00, 0, 8'h00);
        chk("reset_owner",    32'(dbg_owner),    32'(OWN_NONE));
        chk("reset_wait_cnt", 32'(dbg_wait),     32'd0);
        chk("reset_mem_addr", 32'(bus.mem_addr), 32'h000);

        // Directed table.
        for (int i = 0; i < 11; i++) begin
            step(0, tbl[i].creq, tbl[i].cwe, tbl[i].caddr, tbl[i].cwd, tbl[i].dreq, tbl[i].daddr);
            chk($sformatf("row%0d_cpu_gnt", i),     32'(bus.cpu_gnt),     32'(tbl[i].ecg));
            chk($sformatf("row%0d_disp_gnt", i),    32'(bus.disp_gnt),    32'(tbl[i].edg));
            chk($sformatf("row%0d_mem_addr", i),    32'(bus.mem_addr),    32'(tbl[i].eaddr));
            chk($sformatf("row%0d_mem_we", i),      32'(bus.mem_we),      32'(tbl[i].ewe));
            chk($sformatf("row%0d_cpu_rvalid", i),  32'(bus.cpu_rvalid),  32'(tbl[i].ecrv));
            chk($sformatf("row%0d_cpu_rdata", i),   32'(bus.cpu_rdata),   32'(tbl[i].ecrd));
            chk($sformatf("row%0d_disp_rvalid", i), 32'(bus.disp_rvalid), 32'(tbl[i].edrv));
            chk($sformatf("row%0d_disp_rdata", i),  32'(bus.disp_rdata),  32'(tbl[i].edrd));
        end

        // Both requesters held: 8 CPU grants, then one display grant, repeating.
        for (int i = 0; i < 27; i++) begin
            step(0, 1, 0, 12'h020, 8'h00, 1, 8'h10);
            chk($sformatf("rot%0d_cpu_gnt", i),  32'(bus.cpu_gnt),  32'((i % 9) != 8));
            chk($sformatf("rot%0d_disp_gnt", i), 32'(bus.disp_gnt), 32'((i % 9) == 8));
            chk($sformatf("rot%0d_wait_cnt", i), 32'(dbg_wait),     32'(i % 9));
        end

        // Reset in the cycle after a display grant.
        step(0, 0, 0, 12'h000, 8'h00, 1, 8'h38);
        chk("rstseq_disp_gnt", 32'(bus.disp_gnt), 32'd1);
        step(1, 1, 0, 12'h020, 8'h00, 1, 8'h38);
        chk("rstseq_disp_rvalid_in_reset", 32'(bus.disp_rvalid), 32'd0);
        chk("rstseq_disp_rdata_in_reset",  32'(bus.disp_rdata),  32'd0);
        step(1, 1, 0, 12'h020, 8'h00, 1, 8'h38);
        step(0, 0, 0, 12'h000, 8'h00, 0, 8'h00);
        chk("rstseq_disp_rvalid_after", 32'(bus.disp_rvalid), 32'd0);
        chk("rstseq_cpu_rvalid_after",  32'(bus.cpu_rvalid),  32'd0);
        chk("rstseq_wait_cnt_after",    32'(dbg_wait),        32'd0);
        chk("rstseq_mem_addr_after",    32'(bus.mem_addr),    32'h000);

        // Randomized traffic; requesters hold req/address until granted.
        r_creq = 0; r_dreq = 0; r_cwe = 0; r_caddr = '0; r_cwd = '0; r_daddr = '0;
        prev_cg = 0; prev_dg = 0; prev_rst = 0;
        for (int n = 0; n < 600; n++) begin
            r_rst = ($urandom_range(0, 99) == 0);
            if (!r_creq || prev_cg || prev_rst) begin
                r_creq  = ($urandom_range(0, 99) < 65);
                r_cwe   = ($urandom_range(0, 99) < 30);
                r_caddr = 12'($urandom_range(0, 63));
                r_cwd   = 8'($urandom_range(0, 255));
            end
            if (!r_dreq || prev_dg || prev_rst) begin
                r_dreq  = ($urandom_range(0, 99) < 55);
                r_daddr = 8'($urandom_range(0, 255));
            end
            step(r_rst, r_creq, r_cwe, r_caddr, r_cwd, r_dreq, r_daddr);
            prev_cg  = bus.cpu_gnt;
            prev_dg  = bus.disp_gnt;
            prev_rst = r_rst;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_arbiter
